code_entry_checker: RTL and testbench
=====================================

// Module: code_entry_checker
// PURPOSE
//  Keypad digit buffer and serial code comparator that produces the lock controller's data_ready/correct_input/validLength/validLengthPC.
//  Captures digit presses, snapshots an entry on ENTER/LOCK and compares it one digit per cycle against one of:
//    - the stored user code,
//    - the fixed programming passcode,
//    - a staged new code.
//  Holds the user code and commits a staged code on store; sits between the keypad debouncer and the lock controller FSM.
// PARAMETERS
//  BUF_DIGITS   8            entry buffer depth, digits (>= UC_MAX and PC_LEN)
//  UC_MIN       4            minimum user-code length
//  UC_MAX       6            maximum user-code length
//  PC_LEN       8            passcode length, digits
//  PASSCODE     32'h01234560 passcode, 4-bit digits, LS digit = last pressed
//  DEF_UC       24'h000123   reset user code, right-aligned
//  DEF_UC_LEN   4            reset user-code length
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   synchronous active-low reset
//  button         in   4   key code: 0-6 digit, 7 CANCEL, 8 ENTER, 9 LOCK, 10-15 ignored
//  button_valid   in   1   one-cycle strobe per debounced press
//  read_input     in   1   controller is collecting digits
//  check_start    in   1   one-cycle pulse, begin compare
//  check_sel      in   2   00 user code, 01 passcode, 10 staged code, 11 reserved
//  stage          in   1   pulse: copy last entry into staged register
//  store          in   1   pulse: commit staged code to user code
//  data_ready     out  1   one-cycle pulse, compare finished
//  correct_input  out  1   compare result, held until next check_start/CANCEL
//  validLength    out  1   UC_MIN <= count <= UC_MAX and no overflow
//  validLengthPC  out  1   count == PC_LEN and no overflow
//  busy           out  1   compare in progress
//  digit_count    out  4   digits currently in buffer
// BEHAVIOUR
//  Reset: all outputs 0; buffer, entry, staged cleared; staged_valid=0; user code=DEF_UC/DEF_UC_LEN; FSM=IDLE.
//  Buffer: read_input & button_valid & button<=6 -> shift in digit, count+1.
//   - At count==BUF_DIGITS: the digit is dropped and sticky overflow is set.
//   - Rising edge of read_input clears the buffer and overflow.
//  validLength/validLengthPC are registered from count/overflow, so the controller sees pre-press values in the ENTER cycle.
//  ENTER/LOCK (8/9) with read_input: snapshot buffer into entry/entry_len. Buffer clears the next cycle; overflowed entry gets entry_len=0.
//  CANCEL (7), any mode: clear buffer, overflow and entry; abort compare -> IDLE, no data_ready, correct_input=0.
//  FSM IDLE -> CMP -> DONE -> IDLE:
//   - IDLE: check_start latches check_sel, sets idx=0, correct_input=0, busy=1.
//   - CMP, first cycle: length mismatch, or sel=11, or sel=10 & !staged_valid -> DONE with fail.
//   - CMP, otherwise: one digit per cycle; mismatch -> DONE fail; idx==len-1 match -> DONE pass.
//   - DONE: data_ready=1 one cycle, correct_input=result, busy=0 -> IDLE.
//  Latency: start to data_ready = len+1 cycles on pass or late mismatch; 2 cycles on length fail.
//  check_start while busy: ignored. stage while busy: ignored.
//  stage: staged <= entry, staged_valid <= (entry_len in UC_MIN..UC_MAX).
//  store in IDLE & staged_valid: user code <= staged; staged_valid <= 0.
//  store while busy: held pending, applied in the cycle after DONE.
//  store with !staged_valid: no effect.
//  CANCEL and check_start in the same cycle: CANCEL wins.
//  rst_n low mid-compare: immediate return to reset state, no data_ready.
// STRUCTURE
//  lock_pkg: KEY_CANCEL=7, KEY_ENTER=8, KEY_LOCK=9, SEL_UC/SEL_PC/SEL_STG/SEL_RSV, FSM state encodings.
//  Sub-module keypad_digit_buffer: shift buffer, count, overflow, edge-clear, length flags.
//  Top level holds entry/staged/user-code regs, compare FSM, index counter.
// TESTING
//  1 Reset, read_input=1, keys 0,1,2,3,ENTER, check_start sel=00 -> validLength=1 at ENTER; data_ready 5 cycles after start; correct_input=1.
//  2 Keys 0,1,2,4,ENTER, sel=00 -> data_ready 5 cycles after start; correct_input=0.
//  3 Length checks, each with ENTER, sel=01:
//     - 9 digit presses -> overflow; validLengthPC=0; entry_len=0; fail in 2 cycles.
//     - 0,1,2,3,4,5,6,0 -> validLengthPC=1; pass.
//  4 Enter 5,5,5,5,5 then stage; check sel=10 with 5,5,5,5,5 -> pass; store; check sel=00 with 5,5,5,5,5 -> pass.
//     Old code 0,1,2,3 -> fail.
//  5 CANCEL 2 cycles after check_start -> no data_ready; busy=0; digit_count=0; correct_input=0.
//  6 store asserted during CMP -> user code updates the cycle after DONE; sel=10 with staged_valid=0 -> fail.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared key codes, compare-select codes, FSM states and the code payload type
// used by the keypad digit buffer and the code entry checker.
package lock_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned BUF_DIGITS = 8;
    localparam int unsigned UC_MIN     = 4;
    localparam int unsigned UC_MAX     = 6;
    localparam int unsigned PC_LEN     = 8;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned BUF_W      = BUF_DIGITS * DIGIT_W;

    localparam logic [3:0] KEY_DIGIT_MAX = 4'd6;
    localparam logic [3:0] KEY_CANCEL    = 4'd7;
    localparam logic [3:0] KEY_ENTER     = 4'd8;
    localparam logic [3:0] KEY_LOCK      = 4'd9;

    typedef enum logic [1:0] {
        SEL_UC  = 2'b00,
        SEL_PC  = 2'b01,
        SEL_STG = 2'b10,
        SEL_RSV = 2'b11
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Right-aligned digit string; LS digit is the last key pressed.
    typedef struct packed {
        logic [BUF_W-1:0] digits;
        logic [CNT_W-1:0] len;
    } code_t;

    localparam code_t PC_CODE  = '{digits: 32'h0123_4560, len: 4'd8};
    localparam code_t UC_RESET = '{digits: 32'h0000_0123, len: 4'd4};

    function automatic logic uc_len_ok(input logic [CNT_W-1:0] len);
        return (len >= CNT_W'(UC_MIN)) && (len <= CNT_W'(UC_MAX));
    endfunction

endpackage

// File: rtl/keypad_digit_buffer.sv
// Shift buffer for keypad digits with count, sticky overflow and registered
// length-valid flags for the lock controller.
module keypad_digit_buffer
    import lock_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               read_input,
    input  logic               clear,
    input  logic               push,
    input  logic [DIGIT_W-1:0] digit,
    output logic [BUF_W-1:0]   digits,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic               valid_len,
    output logic               valid_len_pc
);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rd_q;
    logic             vl_q, vl_d;
    logic             vlpc_q, vlpc_d;

    always_comb begin
        buf_d  = buf_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clear || (read_input && !rd_q)) begin
            buf_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (push) begin
            if (cnt_q == CNT_W'(BUF_DIGITS)) begin
                ovf_d = 1'b1;
            end else begin
                buf_d = {buf_q[BUF_W-DIGIT_W-1:0], digit};
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // Flags follow the registered count, so they lag a press by one cycle.
        vl_d   = uc_len_ok(cnt_q) && !ovf_q;
        vlpc_d = (cnt_q == CNT_W'(PC_LEN)) && !ovf_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            rd_q   <= 1'b0;
            vl_q   <= 1'b0;
            vlpc_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            rd_q   <= read_input;
            vl_q   <= vl_d;
            vlpc_q <= vlpc_d;
        end
    end

    assign digits       = buf_q;
    assign count        = cnt_q;
    assign overflow     = ovf_q;
    assign valid_len    = vl_q;
    assign valid_len_pc = vlpc_q;

endmodule

// File: rtl/code_entry_checker.sv
// Keypad entry snapshot, staged/user code storage and a serial digit comparator
// that reports pass/fail to the lock controller.
module code_entry_checker
    import lock_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       button,
    input  logic             button_valid,
    input  logic             read_input,
    input  logic             check_start,
    input  logic [1:0]       check_sel,
    input  logic             stage,
    input  logic             store,
    output logic             data_ready,
    output logic             correct_input,
    output logic             validLength,
    output logic             validLengthPC,
    output logic             busy,
    output logic [CNT_W-1:0] digit_count
);

    logic               is_cancel, is_digit, is_snap;
    logic [BUF_W-1:0]   buf_digits;
    logic [CNT_W-1:0]   buf_count;
    logic               buf_ovf;

    state_e             state_q, state_d;
    sel_e               sel_q, sel_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic               result_q, result_d;
    code_t              entry_q, entry_d;
    code_t              staged_q, staged_d;
    logic               staged_valid_q, staged_valid_d;
    code_t              uc_q, uc_d;
    logic               store_pend_q, store_pend_d;
    logic               snap_clr_q, snap_clr_d;
    logic               data_ready_q, data_ready_d;
    logic               correct_q, correct_d;
    logic               busy_q, busy_d;

    code_t              target;
    logic               target_ok;
    logic [CNT_W-1:0]   pos;
    logic [DIGIT_W-1:0] entry_dig, target_dig;

    assign is_cancel = button_valid && (button == KEY_CANCEL);
    assign is_digit  = button_valid && read_input && (button <= KEY_DIGIT_MAX);
    assign is_snap   = button_valid && read_input &&
                       ((button == KEY_ENTER) || (button == KEY_LOCK));

    keypad_digit_buffer u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_input   (read_input),
        .clear        (is_cancel || snap_clr_q),
        .push         (is_digit),
        .digit        (button),
        .digits       (buf_digits),
        .count        (buf_count),
        .overflow     (buf_ovf),
        .valid_len    (validLength),
        .valid_len_pc (validLengthPC)
    );

    // Compare target and the digit pair under test; idx 0 is the first key pressed.
    always_comb begin
        target    = uc_q;
        target_ok = 1'b1;
        case (sel_q)
            SEL_UC:  target = uc_q;
            SEL_PC:  target = PC_CODE;
            SEL_STG: begin
                target    = staged_q;
                target_ok = staged_valid_q;
            end
            SEL_RSV: target_ok = 1'b0;
        endcase
        pos        = entry_q.len - CNT_W'(1) - idx_q;
        entry_dig  = DIGIT_W'(entry_q.digits >> (pos * DIGIT_W));
        target_dig = DIGIT_W'(target.digits >> (pos * DIGIT_W));
    end

    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        idx_d          = idx_q;
        result_d       = result_q;
        entry_d        = entry_q;
        staged_d       = staged_q;
        staged_valid_d = staged_valid_q;
        uc_d           = uc_q;
        store_pend_d   = store_pend_q;
        snap_clr_d     = is_snap;
        data_ready_d   = 1'b0;
        correct_d      = correct_q;
        busy_d         = busy_q;

        if (is_snap) begin
            entry_d.digits = buf_digits;
            entry_d.len    = buf_ovf ? '0 : buf_count;
        end

        if (stage && (state_q == ST_IDLE)) begin
            staged_d       = entry_q;
            staged_valid_d = uc_len_ok(entry_q.len);
        end

        // A store seen mid-compare is parked and committed once back in IDLE.
        if (state_q != ST_IDLE) begin
            if (store) store_pend_d = 1'b1;
        end else if (store || store_pend_q) begin
            store_pend_d = 1'b0;
            if (staged_valid_q) begin
                uc_d           = staged_q;
                staged_valid_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (check_start) begin
                    state_d   = ST_CMP;
                    sel_d     = sel_e'(check_sel);
                    idx_d     = '0;
                    correct_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_CMP: begin
                if (!target_ok || (entry_q.len != target.len) || (entry_dig != target_dig)) begin
                    result_d = 1'b0;
                    state_d  = ST_DONE;
                end else if (idx_q == target.len - CNT_W'(1)) begin
                    result_d = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                data_ready_d = 1'b1;
                correct_d    = result_q;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (is_cancel) begin
            state_d      = ST_IDLE;
            data_ready_d = 1'b0;
            correct_d    = 1'b0;
            busy_d       = 1'b0;
            entry_d      = '0;
            snap_clr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            sel_q          <= SEL_UC;
            idx_q          <= '0;
            result_q       <= 1'b0;
            entry_q        <= '0;
            staged_q       <= '0;
            staged_valid_q <= 1'b0;
            uc_q           <= UC_RESET;
            store_pend_q   <= 1'b0;
            snap_clr_q     <= 1'b0;
            data_ready_q   <= 1'b0;
            correct_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            idx_q          <= idx_d;
            result_q       <= result_d;
            entry_q        <= entry_d;
            staged_q       <= staged_d;
            staged_valid_q <= staged_valid_d;
            uc_q           <= uc_d;
            store_pend_q   <= store_pend_d;
            snap_clr_q     <= snap_clr_d;
            data_ready_q   <= data_ready_d;
            correct_q      <= correct_d;
            busy_q         <= busy_d;
        end
    end

    assign data_ready    = data_ready_q;
    assign correct_input = correct_q;
    assign busy          = busy_q;
    assign digit_count   = buf_count;

endmodule

// File: tb/tb_code_entry_checker.sv
// Scoreboard bench for code_entry_checker: a digit-queue model predicts each
// compare's result and latency, which are checked when data_ready arrives.
module tb_code_entry_checker;

    localparam logic [3:0] K_CANCEL = 4'd7;
    localparam logic [3:0] K_ENTER  = 4'd8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] button;
    logic       button_valid, read_input, check_start, stage, store;
    logic [1:0] check_sel;
    logic       data_ready, correct_input, vl, vlpc, busy;
    logic [3:0] digit_count;

    code_entry_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .button        (button),
        .button_valid  (button_valid),
        .read_input    (read_input),
        .check_start   (check_start),
        .check_sel     (check_sel),
        .stage         (stage),
        .store         (store),
        .data_ready    (data_ready),
        .correct_input (correct_input),
        .validLength   (vl),
        .validLengthPC (vlpc),
        .busy          (busy),
        .digit_count   (digit_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pass;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state, digits kept in press order.
    int cur[$];
    int entry[$];
    int m_uc[$]      = '{0, 1, 2, 3};
    int m_stg[$];
    int pc_digits[$] = '{0, 1, 2, 3, 4, 5, 6, 0};
    bit m_ovf = 0, e_ovf = 0, m_stg_valid = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_cancel();
        cur.delete();
        entry.delete();
        m_ovf = 0;
        e_ovf = 0;
    endfunction

    function automatic void model_stage();
        m_stg       = entry;
        m_stg_valid = !e_ovf && entry.size() >= 4 && entry.size() <= 6;
    endfunction

    function automatic void model_store();
        if (m_stg_valid) begin
            m_uc        = m_stg;
            m_stg_valid = 0;
        end
    endfunction

    function automatic exp_t model_expect(input logic [1:0] sel);
        exp_t e;
        int   t[$];
        bit   ok = 1;
        e.pass = 0;
        e.lat  = 2;
        case (sel)
            2'b00:   t = m_uc;
            2'b01:   t = pc_digits;
            2'b10:   begin t = m_stg; ok = m_stg_valid; end
            default: ok = 0;
        endcase
        if (!ok || e_ovf || entry.size() != t.size()) return e;
        for (int k = 0; k < t.size(); k++) begin
            if (entry[k] != t[k]) begin
                e.lat = k + 2;
                return e;
            end
        end
        e.pass = 1;
        e.lat  = t.size() + 1;
        return e;
    endfunction

    task automatic press(input logic [3:0] k);
        button       = k;
        button_valid = 1;
        tick();
        button_valid = 0;
        button       = 4'd15;
        tick();
        if (k <= 4'd6) begin
            if (cur.size() < 8) cur.push_back(int'(k));
            else m_ovf = 1;
        end else if (k == K_CANCEL) begin
            model_cancel();
        end else if (k == K_ENTER) begin
            entry = cur;
            e_ovf = m_ovf;
            cur.delete();
            m_ovf = 0;
        end
    endtask

    // Press n digits, MS nibble first, check the length flags, then ENTER.
    task automatic enter_code(input logic [39:0] code, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) press(code[i*4 +: 4]);
        chk_eq({tag, "_cnt"}, digit_count, cur.size());
        chk_eq({tag, "_vl"}, vl, !m_ovf && cur.size() >= 4 && cur.size() <= 6);
        chk_eq({tag, "_vlpc"}, vlpc, !m_ovf && cur.size() == 8);
        press(K_ENTER);
    endtask

    task automatic run_check(input logic [1:0] sel, input string tag, input bit store_mid);
        exp_t e;
        int   lat = 0;
        sb.push_back(model_expect(sel));
        check_sel   = sel;
        check_start = 1;
        tick();
        check_start = 0;
        chk_eq({tag, "_busy"}, busy, 1);
        while (!data_ready && lat < 40) begin
            store = store_mid && (lat == 1);
            tick();
            lat++;
        end
        store = 0;
        e = sb.pop_front();
        if (!data_ready) begin
            chk_eq({tag, "_timeout"}, data_ready, 1);
        end else begin
            chk_eq({tag, "_res"}, correct_input, e.pass);
            chk_eq({tag, "_lat"}, lat, e.lat);
            chk_eq({tag, "_idle"}, busy, 0);
        end
        tick();
        chk_eq({tag, "_pulse"}, data_ready, 0);
        chk_eq({tag, "_hold"}, correct_input, e.pass);
        if (store_mid) model_store();
    endtask

    task automatic watch_quiet(input string tag);
        int seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (data_ready) seen++;
            tick();
        end
        chk_eq({tag, "_nodr"}, seen, 0);
        chk_eq({tag, "_busy"}, busy, 0);
        chk_eq({tag, "_cnt"}, digit_count, 0);
        chk_eq({tag, "_corr"}, correct_input, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; button = 4'd15; button_valid = 0; read_input = 0;
        check_start = 0; check_sel = 2'b00; stage = 0; store = 0;
        repeat (3) tick();
        chk_eq("rst_dr", data_ready, 0);
        chk_eq("rst_corr", correct_input, 0);
        chk_eq("rst_vl", vl, 0);
        chk_eq("rst_vlpc", vlpc, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_cnt", digit_count, 0);
        rst_n = 1;
        read_input = 1;
        repeat (2) tick();

        enter_code(40'h0123, 4, "t1");
        run_check(2'b00, "t1_uc", 0);
        enter_code(40'h0124, 4, "t2");
        run_check(2'b00, "t2_uc", 0);

        enter_code(40'h0_1234_5601, 9, "t3o");
        run_check(2'b01, "t3_ovf", 0);
        enter_code(40'h0123_4560, 8, "t3p");
        run_check(2'b01, "t3_pc", 0);
        run_check(2'b11, "t3_rsv", 0);

        enter_code(40'h55555, 5, "t4a");
        stage = 1; tick(); stage = 0; model_stage();
        enter_code(40'h55555, 5, "t4b");
        run_check(2'b10, "t4_stg", 0);
        store = 1; tick(); store = 0; model_store();
        enter_code(40'h55555, 5, "t4c");
        run_check(2'b00, "t4_new", 0);
        enter_code(40'h0123, 4, "t4d");
        run_check(2'b00, "t4_old", 0);

        enter_code(40'h4321, 4, "t6a");
        stage = 1; tick(); stage = 0; model_stage();
        enter_code(40'h55555, 5, "t6b");
        run_check(2'b00, "t6_mid", 1);
        enter_code(40'h4321, 4, "t6c");
        run_check(2'b00, "t6_new", 0);
        run_check(2'b10, "t6_nostg", 0);

        enter_code(40'h4321, 4, "t5");
        check_sel = 2'b00; check_start = 1; tick(); check_start = 0;
        tick();
        press(K_CANCEL);
        watch_quiet("t5_cancel");

        enter_code(40'h4321, 4, "t5b");
        check_sel = 2'b00; check_start = 1; button = K_CANCEL; button_valid = 1;
        tick();
        check_start = 0; button_valid = 0; button = 4'd15;
        model_cancel();
        chk_eq("t5b_busy0", busy, 0);
        watch_quiet("t5b_same");

        enter_code(40'h4321, 4, "t7");
        check_sel = 2'b00; check_start = 1; tick(); check_start = 0;
        tick();
        rst_n = 0; tick();
        chk_eq("t7_busy", busy, 0);
        chk_eq("t7_dr", data_ready, 0);
        rst_n = 1; repeat (2) tick();
        m_uc = '{0, 1, 2, 3}; m_stg_valid = 0; cur.delete(); model_cancel();
        watch_quiet("t7_rst");
        enter_code(40'h0123, 4, "t7b");
        run_check(2'b00, "t7_def", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
